// File: rtl/flash_spi_pkg.sv
// Shared definitions for the flash SPI path.
//   - Flash opcode constants used by the command controller.
//   - Transfer mode encoding (TX / RX).
//   - Byte shift engine state encoding (IDLE / SHIFT).
package flash_spi_pkg;

  localparam logic [7:0] RDID = 8'h9F;
  localparam logic [7:0] RDSR = 8'h05;
  localparam logic [7:0] WREN = 8'h06;
  localparam logic [7:0] BE   = 8'hC7;
  localparam logic [7:0] PP   = 8'h02;
  localparam logic [7:0] READ = 8'h03;

  typedef enum logic {
    MODE_TX = 1'b0,
    MODE_RX = 1'b1
  } spi_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // Index of the last spi_sclk half-period in one byte (16 toggles).
  localparam logic [3:0] HALF_LAST = 4'd15;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 serial clock generator for one byte transfer.
// Ports:
//   sys_clk, sys_rst_n : clock and synchronous active-low reset
//   start              : one-cycle pulse that begins a 16-toggle burst
//   spi_sclk           : registered serial clock, idles low
//   rise / fall        : strobes, high in the cycle whose edge toggles spi_sclk up / down
//   last               : strobe on the final (16th, falling) toggle of the burst
module spi_sclk_gen
  import flash_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic start,
  output logic spi_sclk,
  output logic rise,
  output logic fall,
  output logic last
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic       running;
  logic [7:0] div_cnt;
  logic [3:0] half_cnt;
  logic       tick;

  assign tick = running && (div_cnt == DIV_MAX);
  assign rise = tick && !spi_sclk;
  assign fall = tick && spi_sclk;
  assign last = fall && (half_cnt == HALF_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      running  <= 1'b0;
      div_cnt  <= 8'd0;
      half_cnt <= 4'd0;
      spi_sclk <= 1'b0;
    end else begin
      if (start) begin
        running <= 1'b1;
      end else if (last) begin
        running <= 1'b0;
      end
      if (tick) begin
        div_cnt  <= 8'd0;
        // Wraps 15 -> 0 on the last toggle, leaving the counter ready for
        // a back-to-back start.
        half_cnt <= half_cnt + 4'd1;
        spi_sclk <= ~spi_sclk;
      end else if (running) begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// Byte-level SPI mode-0 shift engine.
// Ports:
//   sys_clk, sys_rst_n : clock and synchronous active-low reset
//   en_tx, tx_data     : one-cycle request to transmit tx_data (MSB first)
//   en_rx              : one-cycle request to receive one byte
//   tx_done, rx_done   : one-cycle completion pulses
//   rx_data            : last received byte, held until the next receive
//   busy               : high while shifting
//   spi_sclk, spi_mosi : serial clock (CPOL=0) and data out
//   spi_miso           : serial data in, sampled on rising spi_sclk
module spi_byte_master
  import flash_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [7:0]  RX_DUMMY = 8'h00
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en_tx,
  input  logic [7:0] tx_data,
  input  logic       en_rx,
  output logic       tx_done,
  output logic       rx_done,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  spi_state_e state, state_nxt;
  spi_mode_e  mode, mode_nxt;
  logic [7:0] sr, sr_nxt;
  logic       miso_bit, miso_bit_nxt;
  logic       mosi_nxt, busy_nxt, tx_done_nxt, rx_done_nxt;
  logic [7:0] rx_data_nxt;
  logic       start, rise, fall, last;

  // Requests are only accepted in IDLE; anything arriving in SHIFT is dropped.
  assign start = (state == IDLE) && (en_tx || en_rx);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .spi_sclk (spi_sclk),
    .rise     (rise),
    .fall     (fall),
    .last     (last)
  );

  // State and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      mode     <= MODE_TX;
      sr       <= 8'h00;
      miso_bit <= 1'b0;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      rx_done  <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      sr       <= sr_nxt;
      miso_bit <= miso_bit_nxt;
      spi_mosi <= mosi_nxt;
      busy     <= busy_nxt;
      tx_done  <= tx_done_nxt;
      rx_done  <= rx_done_nxt;
      rx_data  <= rx_data_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_tx || en_rx) state_nxt = SHIFT;
      SHIFT:   if (last)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mode_nxt     = mode;
    sr_nxt       = sr;
    miso_bit_nxt = miso_bit;
    mosi_nxt     = spi_mosi;
    busy_nxt     = busy;
    tx_done_nxt  = 1'b0;
    rx_done_nxt  = 1'b0;
    rx_data_nxt  = rx_data;
    case (state)
      IDLE: begin
        // TX has priority when both requests arrive together.
        if (en_tx) begin
          sr_nxt   = tx_data;
          mode_nxt = MODE_TX;
          mosi_nxt = tx_data[7];
          busy_nxt = 1'b1;
        end else if (en_rx) begin
          sr_nxt   = RX_DUMMY;
          mode_nxt = MODE_RX;
          mosi_nxt = RX_DUMMY[7];
          busy_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (rise) begin
          miso_bit_nxt = spi_miso;
        end
        if (fall) begin
          sr_nxt   = {sr[6:0], miso_bit};
          // spi_mosi tracks the new sr[7] for the next rising edge.
          mosi_nxt = sr[6];
        end
        if (last) begin
          mosi_nxt = 1'b0;
          busy_nxt = 1'b0;
          if (mode == MODE_TX) begin
            tx_done_nxt = 1'b1;
          end else begin
            rx_done_nxt = 1'b1;
            rx_data_nxt = {sr[6:0], miso_bit};
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: dut_a at CLK_DIV=2, dut_b at CLK_DIV=1.
module tb_spi_byte_master;
  import flash_spi_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;

  logic       en_tx, en_rx, spi_miso;
  logic [7:0] tx_data;
  logic       tx_done, rx_done, busy, spi_sclk, spi_mosi;
  logic [7:0] rx_data;

  logic       en_tx_b, en_rx_b, spi_miso_b;
  logic [7:0] tx_data_b;
  logic       tx_done_b, rx_done_b, busy_b, spi_sclk_b, spi_mosi_b;
  logic [7:0] rx_data_b;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  spi_byte_master #(.CLK_DIV(2), .RX_DUMMY(8'h00)) dut_a (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en_tx    (en_tx),
    .tx_data  (tx_data),
    .en_rx    (en_rx),
    .tx_done  (tx_done),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .busy     (busy),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  spi_byte_master #(.CLK_DIV(1), .RX_DUMMY(8'h00)) dut_b (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en_tx    (en_tx_b),
    .tx_data  (tx_data_b),
    .en_rx    (en_rx_b),
    .tx_done  (tx_done_b),
    .rx_done  (rx_done_b),
    .rx_data  (rx_data_b),
    .busy     (busy_b),
    .spi_sclk (spi_sclk_b),
    .spi_mosi (spi_mosi_b),
    .spi_miso (spi_miso_b)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer on dut_a (CLK_DIV=2), called at cycle 0 of the request.
  // Slave model presents bit 7 before the first rise and shifts on each fall.
  task automatic xfer(input bit do_tx, input bit do_rx, input logic [7:0] data,
                      input logic [7:0] sbyte, input int extra_at,
                      input logic [7:0] exp_mosi, input logic [7:0] exp_rx,
                      input string tag);
    logic [7:0] slave_sr;
    logic [7:0] mosi_bits;
    logic       prev;
    logic       rx_mode;
    int         rises;
    int         falls;
    rx_mode   = !do_tx && do_rx;
    slave_sr  = sbyte;
    spi_miso  = slave_sr[7];
    mosi_bits = 8'h00;
    rises     = 0;
    falls     = 0;
    check1({tag, " sclk idle c0"}, spi_sclk, 1'b0);
    prev    = spi_sclk;
    en_tx   = do_tx;
    en_rx   = do_rx;
    tx_data = data;
    for (int c = 1; c <= 33; c++) begin
      tick();
      en_tx = 1'b0;
      en_rx = 1'b0;
      if (c == extra_at) begin
        en_tx   = 1'b1;
        tx_data = 8'hFF;
      end
      if (!prev && spi_sclk) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], spi_mosi};
      end
      if (prev && !spi_sclk) begin
        falls++;
        slave_sr = {slave_sr[6:0], 1'b0};
        spi_miso = slave_sr[7];
      end
      prev = spi_sclk;
      check1($sformatf("%s busy c%0d", tag, c), busy, c <= 32);
      check1($sformatf("%s tx_done c%0d", tag, c), tx_done, (c == 33) && !rx_mode);
      check1($sformatf("%s rx_done c%0d", tag, c), rx_done, (c == 33) && rx_mode);
      if (rx_mode) check1($sformatf("%s mosi dummy c%0d", tag, c), spi_mosi, 1'b0);
    end
    en_tx = 1'b0;
    check8({tag, " rises"}, 8'(rises), 8'd8);
    check8({tag, " falls"}, 8'(falls), 8'd8);
    if (!rx_mode) check8({tag, " mosi bits"}, mosi_bits, exp_mosi);
    check1({tag, " mosi end"}, spi_mosi, 1'b0);
    check1({tag, " sclk end"}, spi_sclk, 1'b0);
    check8({tag, " rx_data"}, rx_data, exp_rx);
  endtask

  initial begin
    logic [7:0] mosi_b_bits;
    logic       prev_b;
    int         rises_b;
    int         stray;

    sys_rst_n  = 1'b0;
    en_tx      = 1'b0;
    en_rx      = 1'b0;
    tx_data    = 8'h00;
    spi_miso   = 1'b0;
    en_tx_b    = 1'b0;
    en_rx_b    = 1'b0;
    tx_data_b  = 8'h00;
    spi_miso_b = 1'b0;

    // Reset state
    repeat (3) tick();
    check1("rst busy", busy, 1'b0);
    check1("rst sclk", spi_sclk, 1'b0);
    check1("rst mosi", spi_mosi, 1'b0);
    check1("rst tx_done", tx_done, 1'b0);
    check1("rst rx_done", rx_done, 1'b0);
    check8("rst rx_data", rx_data, 8'h00);
    sys_rst_n = 1'b1;
    tick();

    // 1: transmit 9F
    xfer(1'b1, 1'b0, RDID, 8'h00, -1, 8'h9F, 8'h00, "t1 tx9F");
    tick();

    // 2: receive 20
    xfer(1'b0, 1'b1, 8'h00, 8'h20, -1, 8'h00, 8'h20, "t2 rx20");
    tick();

    // 3: RDID sequence, request the cycle after each done
    xfer(1'b1, 1'b0, RDID, 8'h00, -1, 8'h9F, 8'h20, "t3 cmd");
    tick();
    xfer(1'b0, 1'b1, 8'h00, 8'h20, -1, 8'h00, 8'h20, "t3 id0");
    tick();
    xfer(1'b0, 1'b1, 8'h00, 8'h20, -1, 8'h00, 8'h20, "t3 id1");
    tick();
    xfer(1'b0, 1'b1, 8'h00, 8'h15, -1, 8'h00, 8'h15, "t3 id2");
    tick();

    // 4: simultaneous requests (TX wins), second en_tx mid-transfer ignored
    xfer(1'b1, 1'b1, 8'hA5, 8'hFF, 10, 8'hA5, 8'h15, "t4 both");
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy || tx_done || rx_done || spi_sclk) stray++;
    end
    check8("t4 no follow-on", 8'(stray), 8'd0);

    // 5: reset at cycle 12 of a transfer
    tx_data = 8'h9F;
    en_tx   = 1'b1;
    tick();
    en_tx = 1'b0;
    repeat (11) tick();
    sys_rst_n = 1'b0;
    tick();
    check1("t5 sclk", spi_sclk, 1'b0);
    check1("t5 busy", busy, 1'b0);
    check1("t5 mosi", spi_mosi, 1'b0);
    check1("t5 tx_done", tx_done, 1'b0);
    check8("t5 rx_data", rx_data, 8'h00);
    sys_rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy || tx_done || rx_done || spi_sclk) stray++;
    end
    check8("t5 no done", 8'(stray), 8'd0);
    xfer(1'b1, 1'b0, 8'h55, 8'h00, -1, 8'h55, 8'h00, "t5 tx55");
    tick();

    // 6: CLK_DIV=1 transmit C7
    check1("t6 sclk idle", spi_sclk_b, 1'b0);
    tx_data_b   = BE;
    en_tx_b     = 1'b1;
    prev_b      = spi_sclk_b;
    rises_b     = 0;
    mosi_b_bits = 8'h00;
    for (int c = 1; c <= 17; c++) begin
      tick();
      en_tx_b = 1'b0;
      if (!prev_b && spi_sclk_b) begin
        rises_b++;
        mosi_b_bits = {mosi_b_bits[6:0], spi_mosi_b};
      end
      prev_b = spi_sclk_b;
      check1($sformatf("t6 busy c%0d", c), busy_b, c <= 16);
      check1($sformatf("t6 tx_done c%0d", c), tx_done_b, c == 17);
      check1($sformatf("t6 rx_done c%0d", c), rx_done_b, 1'b0);
    end
    check8("t6 rises", 8'(rises_b), 8'd8);
    check8("t6 mosi bits", mosi_b_bits, 8'hC7);
    check1("t6 sclk end", spi_sclk_b, 1'b0);
    tick();
    check1("t6 tx_done clears", tx_done_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
